halt_controller: RTL and testbench
==================================

# halt_controller

Parametrised CPU halt controller in the control unit, successor to the fixed-source terminator. Gathers NUM_FAULTS fault lines plus the halt instruction and an internal watchdog, and classifies each fault as immediate or deferred to the next instruction boundary. Records a priority-encoded halt cause and supports a resume handshake. `halted` gates fetch/decode and execute exactly as the previous terminator's output did.

## Interface
- NUM_FAULTS, 4, number of external fault inputs (1..8)
- DEFER_MASK, 4'b0010, bit i = 1 means fault i takes effect at the next `instruction_end` (pc_overflow style); 0 means immediate (stack_overflow style)
- WDOG_W, 16, watchdog counter width
- WDOG_LIMIT, 16'hFFFF, cycles in RUN without `instruction_end` before a watchdog halt; 0 disables the watchdog
- CAUSE_W, 4, halt-cause width; must hold NUM_FAULTS+2

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- decode  in  1  decode-stage strobe; its first assertion marks CPU start
- halt_instruction  in  1  HLT decoded this cycle
- instruction_end  in  1  last cycle of current instruction
- fault  in  NUM_FAULTS  level fault sources
- resume  in  1  single-cycle request to leave HALTED
- halted  out  1  CPU halted (combinational on the event cycle, then registered)
- halt_cause  out  CAUSE_W  0 none, 1 halt instruction, 2 watchdog, 3+i fault i
- resume_ack  out  1  one-cycle pulse when a resume is accepted

## Operation
States are IDLE, RUN, DRAIN and HALTED.

Event classes (RUN/DRAIN):
- halt_evt = (`halt_instruction` & state≠IDLE) | any immediate fault | watchdog expiry | (state==DRAIN & `instruction_end`)
- Immediate faults are honoured in IDLE too. `halt_instruction` is ignored in IDLE, because garbage decode before start must not halt.

Transitions:
- IDLE -> RUN when `decode`=1.
- IDLE -> HALTED on an immediate fault.
- RUN -> DRAIN when a deferred fault is asserted and no immediate event occurs. The lowest-index deferred fault is latched as the pending cause. If `instruction_end` is also high that cycle, go straight to HALTED instead.
- RUN/DRAIN -> HALTED on halt_evt.
- HALTED -> RUN on `resume`=1 only if no fault is asserted that cycle. Otherwise resume is ignored and `resume_ack` stays 0.
- HALTED holds indefinitely otherwise. `decode` and `halt_instruction` are ignored.

Cause priority when several events share a cycle:
1. lowest-index immediate fault
2. halt instruction
3. watchdog
4. latched deferred fault

- `halt_cause` is captured on entry to HALTED, holds while HALTED, and clears to 0 on accepted resume.
- A deferred fault that drops while in DRAIN still halts; the cause is latched.
- Watchdog counter: cleared on reset, on `instruction_end`, and on leaving HALTED. Increments each RUN/DRAIN cycle and saturates. Expiry fires when count == WDOG_LIMIT-1 and `instruction_end`=0.

## Timing
- Reset values: state IDLE, `halted`=0, `halt_cause`=0, `resume_ack`=0, watchdog=0, pending cause=0. Reset overrides every event in the same cycle, including an asserted fault.
- `halted` = halt_evt_comb | (state==HALTED). It rises in the same cycle as the event (zero latency) and stays high from the next edge.
- `halt_cause` is valid from the edge after the event cycle.
- Deferred fault: `halted` rises in the cycle `instruction_end` is sampled high in DRAIN.
- Resume: `resume` sampled in cycle N gives `resume_ack`=1 and `halted`=0 in cycle N+1 (state RUN).
- A new halt event in cycle N+1 re-halts with zero latency.

## Test plan
- Reset then `halt_instruction`=1 with no prior `decode` -> `halted` stays 0. Pulse `decode`, then `halt_instruction` -> `halted`=1 same cycle, `halt_cause`=1 next cycle, and it holds 20 cycles.
- fault[1] (deferred) pulsed mid-instruction, `instruction_end` 3 cycles later -> `halted`=0 for those 3 cycles, 1 on the end cycle, `halt_cause`=4.
- fault[0] and `halt_instruction` in the same cycle -> `halt_cause`=3. Then `resume` with fault[0] still high -> ignored. Drop the fault, pulse `resume` -> `resume_ack`=1, `halted`=0, `halt_cause`=0.
- WDOG_LIMIT=8, RUN with no `instruction_end` -> `halted` rises in the 8th RUN cycle, `halt_cause`=2. With `instruction_end` every 5 cycles -> never halts.
- Assert `reset` while HALTED with fault[2] high -> next cycle state IDLE, all outputs 0. `halted` reasserts the cycle after reset drops if fault[2] is still immediate and high.

Source files
------------

// File: rtl/halt_controller.sv
`default_nettype none
// ============================================================================
//  Module   : halt_controller
//  Purpose  : CPU halt controller. Merges NUM_FAULTS fault lines, the halt
//             instruction and an internal watchdog into a single `halted`
//             flag that gates fetch/decode and execute. Each fault is either
//             immediate or deferred to the next instruction boundary. It
//             records a priority-encoded halt cause and supports a resume
//             handshake.
//  Ports    : clk              - system clock, rising edge
//             reset            - synchronous, active-high
//             decode           - decode strobe; first assertion = CPU start
//             halt_instruction - HLT decoded this cycle
//             instruction_end  - last cycle of current instruction
//             fault            - level fault sources, one per bit
//             resume           - single-cycle request to leave HALTED
//             halted           - CPU halted (zero-latency on the event cycle)
//             halt_cause       - 0 none, 1 HLT, 2 watchdog, 3+i fault i
//             resume_ack       - one-cycle pulse on accepted resume
//  Revision : 1.0  initial release
// ============================================================================
module halt_controller #(
    parameter int                     NUM_FAULTS = 4,
    parameter logic [NUM_FAULTS-1:0]  DEFER_MASK = 4'b0010,
    parameter int                     WDOG_W     = 16,
    parameter logic [WDOG_W-1:0]      WDOG_LIMIT = 16'hFFFF,
    parameter int                     CAUSE_W    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   decode,
    input  logic                   halt_instruction,
    input  logic                   instruction_end,
    input  logic [NUM_FAULTS-1:0]  fault,
    input  logic                   resume,
    output logic                   halted,
    output logic [CAUSE_W-1:0]     halt_cause,
    output logic                   resume_ack
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [CAUSE_W-1:0] c_cause_hlt  = CAUSE_W'(1);
    localparam logic [CAUSE_W-1:0] c_cause_wdog = CAUSE_W'(2);
    localparam logic [WDOG_W-1:0]  c_wdog_last  = WDOG_LIMIT - WDOG_W'(1);

    state_t                 r_state;
    logic [WDOG_W-1:0]      r_wdog_cnt;
    logic [CAUSE_W-1:0]     r_pending_cause;
    logic [CAUSE_W-1:0]     r_halt_cause;
    logic                   r_resume_ack;

    logic [NUM_FAULTS-1:0]  w_imm_fault;
    logic [NUM_FAULTS-1:0]  w_def_fault;
    logic                   w_active;
    logic                   w_hlt;
    logic                   w_wdog_exp;
    logic                   w_def_now;
    logic                   w_drain_end;
    logic                   w_halt_evt;
    logic                   w_resume_ok;
    logic [CAUSE_W-1:0]     w_evt_cause;

    // Cause code of the lowest-index set bit (3+i); 0 when none set.
    function automatic logic [CAUSE_W-1:0] f_lowest_cause(input logic [NUM_FAULTS-1:0] vec);
        logic [CAUSE_W-1:0] w_res;
        w_res = '0;
        for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                w_res = CAUSE_W'(i + 3);
            end
        end
        return w_res;
    endfunction

    assign w_imm_fault = fault & ~DEFER_MASK;
    assign w_def_fault = fault & DEFER_MASK;
    assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
    // HLT before the first decode is garbage and must not halt.
    assign w_hlt       = halt_instruction && w_active;
    assign w_wdog_exp  = (WDOG_LIMIT != '0) && w_active &&
                         (r_wdog_cnt == c_wdog_last) && !instruction_end;
    // A deferred fault arriving on the boundary cycle itself skips DRAIN.
    assign w_def_now   = (r_state == S_RUN) && (|w_def_fault) && instruction_end;
    assign w_drain_end = (r_state == S_DRAIN) && instruction_end;
    assign w_halt_evt  = !reset && (r_state != S_HALTED) &&
                         ((|w_imm_fault) || w_hlt || w_wdog_exp || w_drain_end || w_def_now);
    assign w_resume_ok = resume && !(|fault);

    always_comb begin
        w_evt_cause = '0;
        if (|w_imm_fault) begin
            w_evt_cause = f_lowest_cause(w_imm_fault);
        end else if (w_hlt) begin
            w_evt_cause = c_cause_hlt;
        end else if (w_wdog_exp) begin
            w_evt_cause = c_cause_wdog;
        end else if (r_state == S_DRAIN) begin
            w_evt_cause = r_pending_cause;
        end else begin
            w_evt_cause = f_lowest_cause(w_def_fault);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_wdog_cnt      <= '0;
            r_pending_cause <= '0;
            r_halt_cause    <= '0;
            r_resume_ack    <= 1'b0;
        end else begin
            r_resume_ack <= 1'b0;

            if (instruction_end || ((r_state == S_HALTED) && w_resume_ok)) begin
                r_wdog_cnt <= '0;
            end else if (w_active && (r_wdog_cnt != '1)) begin
                r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_halt_evt) begin
                        r_state      <= S_HALTED;
                        r_halt_cause <= w_evt_cause;
                    end else if (decode) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_halt_evt) begin
                        r_state      <= S_HALTED;
                        r_halt_cause <= w_evt_cause;
                    end else if (|w_def_fault) begin
                        r_state         <= S_DRAIN;
                        r_pending_cause <= f_lowest_cause(w_def_fault);
                    end
                end
                S_DRAIN: begin
                    // Pending cause stays latched even if the fault drops.
                    if (w_halt_evt) begin
                        r_state      <= S_HALTED;
                        r_halt_cause <= w_evt_cause;
                    end
                end
                S_HALTED: begin
                    if (w_resume_ok) begin
                        r_state         <= S_RUN;
                        r_halt_cause    <= '0;
                        r_pending_cause <= '0;
                        r_resume_ack    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign halted     = w_halt_evt || (r_state == S_HALTED);
    assign halt_cause = r_halt_cause;
    assign resume_ack = r_resume_ack;

endmodule
`default_nettype wire

// File: tb/tb_halt_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_halt_controller
//  Purpose  : Self-checking bench for halt_controller: directed vector table,
//             hand-written multi-cycle sequences and randomized stimulus, all
//             compared against a flag-based behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_halt_controller;

    localparam logic [3:0] DEFER = 4'b0010;
    localparam int         WLIM  = 8;

    logic       clk = 1'b0;
    logic       reset, decode, halt_instruction, instruction_end, resume;
    logic [3:0] fault;
    logic       halted, resume_ack;
    logic [3:0] halt_cause;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    halt_controller #(
        .NUM_FAULTS (4),
        .DEFER_MASK (DEFER),
        .WDOG_W     (16),
        .WDOG_LIMIT (16'(WLIM)),
        .CAUSE_W    (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .decode           (decode),
        .halt_instruction (halt_instruction),
        .instruction_end  (instruction_end),
        .fault            (fault),
        .resume           (resume),
        .halted           (halted),
        .halt_cause       (halt_cause),
        .resume_ack       (resume_ack)
    );

    // ---------------- behavioural model ----------------
    bit m_started, m_halted, m_ack;
    int m_pending = -1;
    int m_cause   = 0;
    int m_cnt     = 0;
    bit e_evt;
    int e_cause;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_eval(input logic r, h, e, input logic [3:0] f);
        logic [3:0] imm, def;
        imm = f & ~DEFER;
        def = f & DEFER;
        e_evt   = 1'b0;
        e_cause = 0;
        if (!r && !m_halted) begin
            if (imm != 0)                          e_cause = 3 + lowest(imm);
            else if (m_started) begin
                if (h)                             e_cause = 1;
                else if (m_cnt == WLIM - 1 && !e)  e_cause = 2;
                else if (e && m_pending >= 0)      e_cause = 3 + m_pending;
                else if (e && def != 0)            e_cause = 3 + lowest(def);
            end
            e_evt = (e_cause != 0);
        end
    endtask

    task automatic model_update(input logic r, d, e, input logic [3:0] f, input logic rs);
        int n_cnt;
        if (r) begin
            m_started = 0; m_halted = 0; m_ack = 0;
            m_pending = -1; m_cause = 0; m_cnt = 0;
        end else begin
            if (e)                                              n_cnt = 0;
            else if (m_started && !m_halted && m_cnt < 65535)   n_cnt = m_cnt + 1;
            else                                                n_cnt = m_cnt;
            m_ack = 0;
            if (m_halted) begin
                if (rs && f == 0) begin
                    m_halted = 0; m_started = 1; m_ack = 1;
                    m_cause = 0; m_pending = -1; n_cnt = 0;
                end
            end else if (e_evt) begin
                m_halted = 1; m_cause = e_cause;
            end else if (!m_started) begin
                if (d) m_started = 1;
            end else if (m_pending < 0 && (f & DEFER) != 0) begin
                m_pending = lowest(f & DEFER);
            end
            m_cnt = n_cnt;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // mode 0: no compare, 1: model only, 2: model plus given constants
    task automatic run_cycle(input int mode, input logic r, d, h, e,
                             input logic [3:0] f, input logic rs,
                             input logic xh, input logic [3:0] xc, input logic xa);
        reset = r; decode = d; halt_instruction = h;
        instruction_end = e; fault = f; resume = rs;
        @(negedge clk);
        model_eval(r, h, e, f);
        if (mode >= 1) begin
            check("halted_model", int'(halted), int'(m_halted | e_evt));
            check("cause_model",  int'(halt_cause), m_cause);
            check("ack_model",    int'(resume_ack), int'(m_ack));
        end
        if (mode == 2) begin
            check("halted_vec", int'(halted), int'(xh));
            check("cause_vec",  int'(halt_cause), int'(xc));
            check("ack_vec",    int'(resume_ack), int'(xa));
        end
        model_update(r, d, e, f, rs);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic r, d, h, e;
        logic [3:0] f;
        logic rs;
        logic xh;
        logic [3:0] xc;
        logic xa;
    } vec_t;

    function automatic vec_t v(input logic r, d, h, e, input logic [3:0] f,
                               input logic rs, xh, input logic [3:0] xc, input logic xa);
        vec_t t;
        t.r = r; t.d = d; t.h = h; t.e = e; t.f = f; t.rs = rs;
        t.xh = xh; t.xc = xc; t.xa = xa;
        return t;
    endfunction

    vec_t tbl[28];

    initial begin
        //            r  d  h  e  fault    rs  | halted cause ack
        tbl[0]  = v(1, 0, 0, 0, 4'b0000, 0,   0, 0, 0); // reset state
        tbl[1]  = v(0, 0, 1, 0, 4'b0000, 0,   0, 0, 0); // HLT before start ignored
        tbl[2]  = v(0, 0, 1, 0, 4'b0000, 0,   0, 0, 0);
        tbl[3]  = v(0, 1, 0, 0, 4'b0000, 0,   0, 0, 0); // start
        tbl[4]  = v(0, 0, 1, 0, 4'b0000, 0,   1, 0, 0); // HLT: zero latency
        tbl[5]  = v(0, 0, 0, 0, 4'b0000, 0,   1, 1, 0);
        tbl[6]  = v(0, 0, 0, 0, 4'b0000, 1,   1, 1, 0); // resume
        tbl[7]  = v(0, 0, 0, 0, 4'b0000, 0,   0, 0, 1);
        tbl[8]  = v(0, 0, 0, 0, 4'b0010, 0,   0, 0, 0); // deferred fault pulse
        tbl[9]  = v(0, 0, 0, 0, 4'b0000, 0,   0, 0, 0);
        tbl[10] = v(0, 0, 0, 0, 4'b0000, 0,   0, 0, 0);
        tbl[11] = v(0, 0, 0, 1, 4'b0000, 0,   1, 0, 0); // boundary: halt
        tbl[12] = v(0, 0, 0, 0, 4'b0000, 0,   1, 4, 0);
        tbl[13] = v(0, 0, 0, 0, 4'b0000, 1,   1, 4, 0);
        tbl[14] = v(0, 0, 0, 0, 4'b0000, 0,   0, 0, 1);
        tbl[15] = v(0, 0, 1, 0, 4'b0001, 0,   1, 0, 0); // fault0 beats HLT
        tbl[16] = v(0, 0, 0, 0, 4'b0001, 1,   1, 3, 0); // resume refused
        tbl[17] = v(0, 0, 0, 0, 4'b0001, 0,   1, 3, 0);
        tbl[18] = v(0, 0, 0, 0, 4'b0000, 1,   1, 3, 0);
        tbl[19] = v(0, 0, 0, 0, 4'b0000, 0,   0, 0, 1);
        tbl[20] = v(0, 0, 0, 0, 4'b0100, 0,   1, 0, 0); // immediate fault2
        tbl[21] = v(0, 0, 0, 0, 4'b0100, 0,   1, 5, 0);
        tbl[22] = v(1, 0, 0, 0, 4'b0100, 0,   1, 5, 0); // reset while halted
        tbl[23] = v(1, 0, 0, 0, 4'b0100, 0,   0, 0, 0);
        tbl[24] = v(0, 0, 0, 0, 4'b0100, 0,   1, 0, 0); // IDLE immediate fault
        tbl[25] = v(0, 0, 0, 0, 4'b0100, 0,   1, 5, 0);
        tbl[26] = v(1, 0, 0, 0, 4'b0000, 0,   1, 5, 0);
        tbl[27] = v(1, 0, 0, 0, 4'b0000, 0,   0, 0, 0);
    end

    initial begin
        reset = 1'b1; decode = 0; halt_instruction = 0;
        instruction_end = 0; fault = '0; resume = 0;
        @(posedge clk);
        #1;
        run_cycle(0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        run_cycle(0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);

        for (int i = 0; i < 28; i++) begin
            run_cycle(2, tbl[i].r, tbl[i].d, tbl[i].h, tbl[i].e, tbl[i].f, tbl[i].rs,
                      tbl[i].xh, tbl[i].xc, tbl[i].xa);
        end

        // HLT cause holds for 20 cycles with unrelated activity ignored
        run_cycle(2, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
        run_cycle(2, 0, 0, 1, 0, 4'b0000, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            run_cycle(2, 0, 1, 1, i[0], 4'b0000, 0, 1, 1, 0);
        end

        // Watchdog expiry: halts in the 8th RUN cycle without a boundary
        run_cycle(2, 1, 0, 0, 0, 4'b0000, 0, 1, 1, 0);
        run_cycle(2, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        run_cycle(2, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < WLIM - 1; i++) begin
            run_cycle(2, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        end
        run_cycle(2, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
        run_cycle(2, 0, 0, 0, 0, 4'b0000, 0, 1, 2, 0);

        // Boundary every 5 cycles keeps the watchdog quiet
        run_cycle(2, 1, 0, 0, 0, 4'b0000, 0, 1, 2, 0);
        run_cycle(2, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        run_cycle(2, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            run_cycle(2, 0, 0, 0, (i % 5 == 4), 4'b0000, 0, 0, 0, 0);
        end

        // Randomized stimulus against the model
        run_cycle(1, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic       r, d, h, e, rs;
            logic [3:0] f;
            r  = ($urandom_range(0, 63) == 0);
            d  = ($urandom_range(0, 3) == 0);
            h  = ($urandom_range(0, 15) == 0);
            e  = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            run_cycle(1, r, d, h, e, f, rs, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
